// File: rtl/wptr_handler_if.sv
// Write-side handshake bundle for an asynchronous FIFO write pointer handler.
//   winc        : write request for the current cycle
//   rptr        : Gray-coded read pointer arriving from the read clock domain
//   wptr        : registered Gray-coded write pointer sent to the read domain
//   waddr       : binary write address into the FIFO memory
//   full        : registered FIFO-full flag
//   almost_full : registered fill-level threshold flag
//   wlevel      : write-side view of the fill level
//   overflow    : sticky flag, a write was attempted while full
// master = the write-side client / read-domain source, slave = wptr_handler.
interface wptr_handler_if #(
    parameter int ADDR_WIDTH = 5
);
    logic                  winc;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-2:0] waddr;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH-1:0] wlevel;
    logic                  overflow;

    modport master (
        output winc, rptr,
        input  wptr, waddr, full, almost_full, wlevel, overflow
    );

    modport slave (
        input  winc, rptr,
        output wptr, waddr, full, almost_full, wlevel, overflow
    );
endinterface

// File: rtl/wptr_handler.sv
// Write-domain pointer handler for an asynchronous FIFO.
// Keeps the binary write pointer, publishes it in Gray code, synchronises the
// read pointer through two flops and derives full / almost_full / level.
// Ports:
//   wclk  : write clock, all flops rising-edge
//   w_rst : synchronous active-high reset
//   wif   : wptr_handler_if.slave bundle (winc, rptr in; wptr, waddr, full,
//           almost_full, wlevel, overflow out)
// ADDR_WIDTH must be at least 3; FIFO depth is 2^(ADDR_WIDTH-1).
module wptr_handler #(
    parameter int ADDR_WIDTH   = 5,
    parameter int AFULL_THRESH = 12
) (
    input  logic           wclk,
    input  logic           w_rst,
    wptr_handler_if.slave  wif
);
    localparam int AW = ADDR_WIDTH;
    localparam logic [AW-1:0] AFULL_LVL = AW'(AFULL_THRESH);

    logic [AW-1:0] rq1_q, rq1_d;
    logic [AW-1:0] rq2_q, rq2_d;
    logic [AW-1:0] wbin_q, wbin_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] wlevel_q, wlevel_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          ovf_q, ovf_d;

    logic [AW-1:0] wbin_next;
    logic [AW-1:0] rbin_sync;
    logic [AW-1:0] level_next;
    logic          wr_accept;

    function automatic logic [AW-1:0] gray2bin(input logic [AW-1:0] g);
        logic [AW-1:0] b;
        b[AW-1] = g[AW-1];
        for (int i = AW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    always_comb begin
        // Acceptance uses the registered full, so a write on the edge where
        // full drops is still refused and must be retried.
        wr_accept  = wif.winc & ~full_q;
        wbin_next  = wbin_q + AW'(wr_accept);
        rbin_sync  = gray2bin(rq2_q);
        level_next = wbin_next - rbin_sync;

        rq1_d    = wif.rptr;
        rq2_d    = rq1_q;
        wbin_d   = wbin_next;
        wptr_d   = wbin_next ^ (wbin_next >> 1);
        // Full when the pointers differ only in the wrap bit: in Gray code
        // that is the top two bits inverted and the rest equal.
        full_d   = (wptr_d == {~rq2_q[AW-1:AW-2], rq2_q[AW-3:0]});
        wlevel_d = level_next;
        afull_d  = (level_next >= AFULL_LVL);
        ovf_d    = ovf_q | (wif.winc & full_q);
    end

    always_ff @(posedge wclk) begin
        if (w_rst) begin
            rq1_q    <= '0;
            rq2_q    <= '0;
            wbin_q   <= '0;
            wptr_q   <= '0;
            wlevel_q <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            rq1_q    <= rq1_d;
            rq2_q    <= rq2_d;
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wlevel_q <= wlevel_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
        end
    end

    assign wif.wptr        = wptr_q;
    assign wif.waddr       = wbin_q[AW-2:0];
    assign wif.full        = full_q;
    assign wif.almost_full = afull_q;
    assign wif.wlevel      = wlevel_q;
    assign wif.overflow    = ovf_q;

endmodule

// File: tb/tb_wptr_handler.sv
// Scoreboard bench for wptr_handler (ADDR_WIDTH=5, AFULL_THRESH=12, depth 16).
// The driver computes each edge's expected outputs from occupancy arithmetic
// (accepted-write count minus the read count seen two edges late) and queues
// them; the monitor pops one entry per edge and compares.
module tb_wptr_handler;
    localparam int AW    = 5;
    localparam int DEPTH = 16;
    localparam int THR   = 12;
    localparam int MODV  = 32;

    logic wclk = 1'b0;
    logic w_rst;

    always #5 wclk = ~wclk;

    wptr_handler_if #(.ADDR_WIDTH(AW)) wif ();

    wptr_handler #(
        .ADDR_WIDTH  (AW),
        .AFULL_THRESH(THR)
    ) dut (
        .wclk (wclk),
        .w_rst(w_rst),
        .wif  (wif)
    );

    typedef struct {
        logic [4:0] wptr;
        logic [3:0] waddr;
        logic       full;
        logic       af;
        logic [4:0] lvl;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    bit   started  = 0;
    bit   done     = 0;

    // reference state
    int   m_wb     = 0;   // accepted writes, modulo 32
    bit   m_full   = 0;
    bit   m_ovf    = 0;
    int   rb       = 0;   // read count presented by the read side, modulo 32
    int   edge_n   = 0;
    int   last_rst = 0;
    int   rhist[int];

    function automatic int gray(input int b);
        return (b ^ (b >> 1)) & (MODV - 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s edge=%0d actual=%0h required=%0h", nm, edge_n, act, exp);
        end
    endtask

    // Apply one cycle of stimulus and queue what the following edge must show.
    task automatic step(input bit rst, input bit w);
        exp_t e;
        int   seen;
        int   lvl;
        @(negedge wclk);
        w_rst    = rst;
        wif.winc = w;
        wif.rptr = 5'(gray(rb));
        edge_n++;
        rhist[edge_n] = rb;
        // read count reaches the write side two edges after it is sampled;
        // a reset in between leaves zero in the synchroniser
        seen = (edge_n - last_rst >= 3) ? rhist[edge_n-2] : 0;
        if (rst) begin
            m_wb     = 0;
            m_full   = 0;
            m_ovf    = 0;
            lvl      = 0;
            last_rst = edge_n;
        end else begin
            if (w && m_full) m_ovf = 1;
            if (w && !m_full) m_wb = (m_wb + 1) % MODV;
            lvl    = (m_wb - seen + MODV) % MODV;
            m_full = (lvl == DEPTH);
        end
        e.wptr  = 5'(gray(m_wb));
        e.waddr = 4'(m_wb % DEPTH);
        e.full  = m_full;
        e.af    = (lvl >= THR);
        e.lvl   = 5'(lvl);
        e.ovf   = m_ovf;
        sb.push_back(e);
        started = 1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge wclk);
            #1;
            if (started && !done) begin
                if (sb.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL sb_empty edge=%0d actual=0 required=1 entries", edge_n);
                end else begin
                    e = sb.pop_front();
                    chk("wptr",        32'(wif.wptr),        32'(e.wptr));
                    chk("waddr",       32'(wif.waddr),       32'(e.waddr));
                    chk("full",        32'(wif.full),        32'(e.full));
                    chk("almost_full", 32'(wif.almost_full), 32'(e.af));
                    chk("wlevel",      32'(wif.wlevel),      32'(e.lvl));
                    chk("overflow",    32'(wif.overflow),    32'(e.ovf));
                end
            end
        end
    end

    initial begin : driver
        bit w;
        w_rst    = 1'b1;
        wif.winc = 1'b0;
        wif.rptr = '0;

        step(1, 0);
        step(1, 0);

        // fill from empty with the read side idle
        for (int i = 0; i < DEPTH; i++) step(0, 1);
        // writes while full are dropped and set overflow
        for (int i = 0; i < 3; i++) step(0, 1);
        step(0, 0);
        step(0, 0);
        // read side jumps to 4: full drops on the 3rd edge
        rb = 4;
        for (int i = 0; i < 4; i++) step(0, 0);
        // refill, then hold winc while the read side trickles forward
        for (int i = 0; i < 5; i++) step(0, 1);
        for (int i = 0; i < 15; i++) begin
            if (i % 3 == 0) rb = (rb + 1) % MODV;
            step(0, 1);
        end

        // random traffic, alternating write-heavy and read-heavy stretches
        for (int i = 0; i < 800; i++) begin
            bit rd_heavy;
            rd_heavy = ((i / 50) % 2) == 1;
            w = rd_heavy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            if (((m_wb - rb + MODV) % MODV) > 0 &&
                $urandom_range(0, 3) < (rd_heavy ? 3 : 1))
                rb = (rb + 1) % MODV;
            step(0, w);
        end

        // mid-operation reset with a stale read pointer, then level 9 and
        // a reset that coincides with a write
        step(1, 0);
        rb = 0;
        for (int i = 0; i < 9; i++) step(0, 1);
        step(0, 0);
        step(1, 1);
        step(0, 1);
        for (int i = 0; i < 3; i++) step(0, 0);

        @(negedge wclk);
        done = 1;
        n_assert++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover actual=%0d required=0 entries", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
